// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with B/H/W/D loads and stores at any alignment,
// a valid/ready request/response handshake, range checking and a registered debug word port.
module data_memory_sized #(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 64,
  parameter int INIT_TEST   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsig,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  input  logic [7:0]        dbg_idx,
  output logic [XLEN-1:0]   dbg_word
);

  localparam int BYTES     = XLEN / 8;
  localparam int IW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int DBG_WORDS = DEPTH_BYTES / BYTES;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic [7:0] mem_t [DEPTH_BYTES];

  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH_BYTES; i++) img[i] = 8'h00;
    if (INIT_TEST != 0)
      for (int i = 0; i < 10; i++)
        if (8 * i < DEPTH_BYTES) img[8*i] = 8'(10 - i);
    return img;
  endfunction

  // Power-up image only; reset never touches the array.
  mem_t mem = init_image();

  state_t             state_reg, state_next;
  logic               ready_reg;
  logic               write_reg;
  logic [1:0]         size_reg;
  logic               unsig_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [XLEN-1:0]    wdata_reg;
  logic               rsp_valid_reg;
  logic [XLEN-1:0]    rdata_reg;
  logic               err_reg;
  logic [XLEN-1:0]    dbg_word_reg;

  logic               accept;
  logic [3:0]         nbytes;
  logic [ADDR_W:0]    end_addr;
  logic               access_err;
  logic               sign_bit;
  logic [XLEN-1:0]    raw;
  logic [XLEN-1:0]    load_ext;
  logic [XLEN-1:0]    dbg_data;
  logic [IW-1:0]      lane_idx [BYTES];
  logic               lane_we  [BYTES];

  assign req_ready  = ready_reg && (state_reg == IDLE);
  assign accept     = req_valid && req_ready;
  assign nbytes     = 4'd1 << size_reg;
  // One extra bit keeps addr + size from wrapping past the top of the address space.
  assign end_addr   = {1'b0, addr_reg} + (ADDR_W+1)'(nbytes);
  assign access_err = ((XLEN == 32) && (size_reg == 2'd3)) || (end_addr > DEPTH_EXT);

  always_comb begin
    sign_bit = 1'b0;
    case (size_reg)
      2'd0:    sign_bit = raw[7];
      2'd1:    sign_bit = raw[15];
      2'd2:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [ADDR_W:0] lane_addr;
    logic            lane_en;

    assign lane_addr    = {1'b0, addr_reg} + (ADDR_W+1)'(gi);
    assign lane_en      = 4'(gi) < nbytes;
    assign lane_idx[gi] = lane_addr[IW-1:0];
    assign lane_we[gi]  = (state_reg == ACCESS) && write_reg && !access_err && lane_en;
    assign raw[8*gi +: 8] = (lane_en && (lane_addr < DEPTH_EXT)) ? mem[lane_idx[gi]] : 8'h00;
    // Lanes above the access size carry the extension fill.
    assign load_ext[8*gi +: 8] = lane_en ? raw[8*gi +: 8] : {8{sign_bit & ~unsig_reg}};
    assign dbg_data[8*gi +: 8] = (32'(dbg_idx) < 32'(DBG_WORDS))
                               ? mem[IW'(32'(dbg_idx) * 32'(BYTES) + 32'(gi))] : 8'h00;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BYTES; k++)
      if (lane_we[k]) mem[lane_idx[k]] <= wdata_reg[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg     <= 1'b0;
      write_reg     <= 1'b0;
      size_reg      <= 2'd0;
      unsig_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      dbg_word_reg  <= '0;
    end else begin
      ready_reg    <= 1'b1;
      dbg_word_reg <= dbg_data;
      if (accept) begin
        write_reg <= req_write;
        size_reg  <= req_size;
        unsig_reg <= req_unsig;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ACCESS) begin
        rsp_valid_reg <= 1'b1;
        err_reg       <= access_err;
        rdata_reg     <= (access_err || write_reg) ? '0 : load_ext;
      end else if ((state_reg == RESP) && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign dbg_word  = dbg_word_reg;

endmodule
